// File: rtl/muldiv_pkg.sv
// Shared funct codes and FSM encoding for the EX-stage
// HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  function automatic logic is_muldiv_op(
    input logic [5:0] f
  );
    return f inside {F_MFHI, F_MTHI, F_MFLO,
                     F_MTLO, F_MULT, F_MULTU,
                     F_DIV, F_DIVU};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or
// restoring divide on a 64-bit accumulator.
module muldiv_step (
  input  logic        i_div,
  input  logic [63:0] i_acc,
  input  logic [31:0] i_b,
  output logic [63:0] o_acc
);

  logic [32:0] w_sum;
  logic [32:0] w_rem;
  logic [31:0] w_diff;
  logic        w_ge;

  // mul: {hi, multiplier}, add into hi then shift right
  assign w_sum = {1'b0, i_acc[63:32]}
               + {1'b0, i_acc[0] ? i_b : 32'd0};

  // div: {rem, quotient}, shift left then trial subtract
  assign w_rem  = {i_acc[63:32], i_acc[31]};
  assign w_ge   = w_rem >= {1'b0, i_b};
  assign w_diff = w_rem[31:0] - i_b;

  always_comb begin
    o_acc = {w_sum, i_acc[31:1]};
    if (i_div) begin
      if (w_ge)
        o_acc = {w_diff, i_acc[30:0], 1'b1};
      else
        o_acc = {w_rem[31:0], i_acc[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit with
// HI/LO registers and pipeline stall.
import muldiv_pkg::*;

module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [5:0]  funct_in,
  input  logic [31:0] RD1_in,
  input  logic [31:0] RD2_in,
  input  logic        flush_in,
  output logic        stall_out,
  output logic        busy_out,
  output logic [31:0] result_out,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  state_t      r_state;
  logic [63:0] r_acc;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [5:0]  r_cnt;
  logic        r_div;
  logic        r_sa;
  logic        r_sb;
  logic        r_bz;

  logic        w_op_mul;
  logic        w_op_div;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [63:0] w_acc_nx;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_neg;

  assign w_op_mul = funct_in == F_MULT
                 || funct_in == F_MULTU;
  assign w_op_div = funct_in == F_DIV
                 || funct_in == F_DIVU;
  assign w_mthi   = funct_in == F_MTHI;
  assign w_mtlo   = funct_in == F_MTLO;
  assign w_signed = funct_in == F_MULT
                 || funct_in == F_DIV;

  assign w_a_neg = w_signed & RD1_in[31];
  assign w_b_neg = w_signed & RD2_in[31];
  assign w_a_mag = w_a_neg ? 32'd0 - RD1_in
                           : RD1_in;
  assign w_b_mag = w_b_neg ? 32'd0 - RD2_in
                           : RD2_in;

  muldiv_step u_step (
    .i_div (r_state == DIV),
    .i_acc (r_acc),
    .i_b   (r_b),
    .o_acc (w_acc_nx)
  );

  assign w_neg  = r_sa ^ r_sb;
  assign w_prod = w_neg ? 64'd0 - r_acc : r_acc;
  assign w_quo  = w_neg ? 32'd0 - r_acc[31:0]
                        : r_acc[31:0];
  assign w_rem  = r_sa ? 32'd0 - r_acc[63:32]
                       : r_acc[63:32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_bz    <= 1'b0;
    end else if (flush_in) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (valid_in) begin
          unique case (1'b1)
            w_op_mul, w_op_div: begin
              r_state <= w_op_div ? DIV : MUL;
              r_div   <= w_op_div;
              r_sa    <= w_a_neg;
              r_sb    <= w_b_neg;
              r_bz    <= RD2_in == 32'd0;
              r_cnt   <= '0;
              r_acc   <= w_op_div
                       ? {32'd0, w_a_mag}
                       : {32'd0, w_b_mag};
              r_b     <= w_op_div ? w_b_mag
                                  : w_a_mag;
            end
            w_mthi:  r_hi <= RD1_in;
            w_mtlo:  r_lo <= RD1_in;
            default: ;
          endcase
        end
        MUL, DIV: begin
          r_acc <= w_acc_nx;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31)
            r_state <= FIX;
        end
        FIX: begin
          r_state <= IDLE;
          if (r_div) begin
            // remainder of a zero divide is the dividend
            r_hi <= w_rem;
            r_lo <= r_bz ? 32'hFFFF_FFFF : w_quo;
          end else begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_out  = r_state != IDLE;
  assign stall_out = busy_out & valid_in
                   & is_muldiv_op(funct_in);
  assign hi_out    = r_hi;
  assign lo_out    = r_lo;

  always_comb begin
    result_out = '0;
    if (funct_in == F_MFHI)
      result_out = r_hi;
    else if (funct_in == F_MFLO)
      result_out = r_lo;
  end

endmodule
